burst_reader: RTL and testbench
===============================

BURST_READER -- requirements
Module: burst_reader

Interface
REQ-001 Parameter DataWidth, default 8: width of data words.
REQ-002 Parameter MaxLen, default 16: largest burst length accepted on cmd_len_i.
REQ-003 Parameter LenWidth, default $clog2(MaxLen+1): width of cmd_len_i.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 reset_i  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid_i  input  1  burst command offered.
REQ-007 cmd_ready_o  output  1  burst command accepted when high with cmd_valid_i.
REQ-008 cmd_len_i  input  LenWidth  number of words to read, 0..MaxLen.
REQ-009 src_rvalid_i  input  1  source has a word available.
REQ-010 src_rready_o  output  1  read request to source; handshake = src_rvalid_i & src_rready_o.
REQ-011 src_data_i  input  DataWidth  source data, valid exactly one cycle after a source handshake (read latency 1).
REQ-012 m_valid_o  output  1  downstream word valid.
REQ-013 m_ready_i  input  1  downstream accepts word.
REQ-014 m_data_o  output  DataWidth  downstream word.
REQ-015 m_last_o  output  1  marks final word of the burst; qualified by m_valid_o.
REQ-016 busy_o  output  1  high whenever state is not IDLE.
REQ-017 done_o  output  1  one-cycle pulse on burst completion.

Function
REQ-018 States SHALL be IDLE, READ, DRAIN; IDLE->READ on command handshake with cmd_len_i>0; READ->DRAIN when cmd_len_i source handshakes have been issued; DRAIN->IDLE on the downstream handshake carrying m_last_o.
REQ-019 cmd_ready_o SHALL equal (state==IDLE) & ~reset_i; cmd_len_i SHALL be latched on command handshake.
REQ-020 Command with cmd_len_i==0 SHALL be accepted, stay in IDLE, issue no reads, emit no words, and pulse done_o the following cycle.
REQ-021 cmd_len_i>MaxLen SHALL be treated as MaxLen.
REQ-022 Block SHALL contain a 3-entry output buffer of {data, last} and a 1-bit in-flight flag set on each source handshake.
REQ-023 src_rready_o SHALL be high only in READ with issued<len and (buffer count + in-flight)<3; it SHALL have no combinational dependence on m_ready_i or src_rvalid_i.
REQ-024 When in-flight is set, src_data_i SHALL be written into the buffer that cycle, with last=1 if it is word index len-1.
REQ-025 m_valid_o SHALL equal (buffer count>0); m_data_o/m_last_o SHALL show the oldest entry; entry removed on m_valid_o & m_ready_i.
REQ-026 Simultaneous buffer push and pop SHALL leave count unchanged and preserve order.
REQ-027 With src_rvalid_i and m_ready_i held high, throughput SHALL be one word per cycle; first word appears on m_valid_o 2 cycles after the first source handshake.
REQ-028 Downstream back-pressure SHALL never lose or duplicate a word; buffer never overflows.
REQ-029 done_o SHALL pulse the cycle after the m_last_o handshake; a new command may be accepted in that same cycle.
REQ-030 Exactly len words SHALL be emitted per burst, m_last_o set on the last only.

Reset
REQ-031 On reset_i: state=IDLE, counters=0, buffer empty, in-flight=0; outputs cmd_ready_o=0 (during reset), src_rready_o=0, m_valid_o=0, m_data_o='0, m_last_o=0, busy_o=0, done_o=0.
REQ-032 Reset mid-burst SHALL abort the burst; src_data_i arriving the cycle after reset deasserts SHALL be discarded.

Verification
REQ-033 len=4, source data 0x11,0x22,0x33,0x44, src_rvalid_i=1, m_ready_i=1 -> four consecutive m_valid_o cycles, m_last_o only with 0x44, done_o one cycle later.
REQ-034 len=0 -> cmd accepted, no src_rready_o, no m_valid_o, done_o pulse next cycle, busy_o stays 0.
REQ-035 len=16, m_ready_i low for 10 cycles mid-burst -> src_rready_o drops once count+in-flight=3, all 16 words delivered in order, none lost.
REQ-036 len=5, src_rvalid_i toggling 1/0 each cycle -> reads only on handshakes, 5 words out, m_last_o on 5th.
REQ-037 reset_i asserted for 1 cycle after 2 of 8 words emitted -> all outputs at reset values, next command len=1 yields single word with m_last_o=1.
REQ-038 Back-to-back commands len=3 then len=2 with second offered during done_o -> 5 words, m_last_o on words 3 and 5, two done_o pulses.

Source files
------------

// File: rtl/burst_reader.sv
// rtl/burst_reader.sv - burst read engine: issues len source reads (latency 1) into a 3-entry
// {data,last} buffer and streams them downstream with last on the final word.
module burst_reader #(
   parameter int DataWidth = 8,
   parameter int MaxLen    = 16,
   parameter int LenWidth  = $clog2(MaxLen + 1)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [LenWidth-1:0]  cmd_len_i,
   input  logic                 src_rvalid_i,
   output logic                 src_rready_o,
   input  logic [DataWidth-1:0] src_data_i,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [DataWidth-1:0] m_data_o,
   output logic                 m_last_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                state_q;
   logic [LenWidth-1:0]   len_q;
   logic [LenWidth-1:0]   issued_q;
   logic [LenWidth-1:0]   recv_q;
   logic                  inflight_q;
   logic                  done_q;
   logic [1:0]            wr_ptr_q;
   logic [1:0]            rd_ptr_q;
   logic [1:0]            count_q;
   logic [DataWidth-1:0]  buf_data_q [3];
   logic                  buf_last_q [3];

   logic [LenWidth-1:0]   cmd_len_eff;
   logic                  cmd_hs;
   logic                  src_hs;
   logic                  push;
   logic                  pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign cmd_len_eff  = (cmd_len_i > LenWidth'(MaxLen)) ? LenWidth'(MaxLen) : cmd_len_i;
   assign cmd_ready_o  = (state_q == IDLE) & ~reset_i;
   assign cmd_hs       = cmd_valid_i & cmd_ready_o;

   // Reads are throttled so every outstanding word already has a buffer slot reserved.
   assign src_rready_o = (state_q == READ) && (issued_q < len_q) &&
                         (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
   assign src_hs       = src_rvalid_i & src_rready_o;

   assign push         = inflight_q;
   assign m_valid_o    = (count_q != 2'd0);
   assign pop          = m_valid_o & m_ready_i;
   assign m_data_o     = m_valid_o ? buf_data_q[rd_ptr_q] : '0;
   assign m_last_o     = m_valid_o & buf_last_q[rd_ptr_q];
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= src_data_i;
         buf_last_q[wr_ptr_q] <= (recv_q == len_q - LenWidth'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         recv_q     <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= src_hs;

         if (push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
            recv_q   <= recv_q + LenWidth'(1);
         end
         if (pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase

         case (state_q)
            IDLE: begin
               if (cmd_hs) begin
                  len_q    <= cmd_len_eff;
                  issued_q <= '0;
                  recv_q   <= '0;
                  if (cmd_len_eff == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               if (src_hs) begin
                  issued_q <= issued_q + LenWidth'(1);
                  if (issued_q + LenWidth'(1) == len_q) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last_o) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_reader.sv
// tb/tb_burst_reader.sv - randomized scoreboard bench for burst_reader.
module tb_burst_reader;
   localparam int DW = 8;
   localparam int ML = 16;
   localparam int LW = $clog2(ML + 1);

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [LW-1:0] cmd_len_i = '0;
   logic          src_rvalid_i = 1'b0;
   logic          src_rready_o;
   logic [DW-1:0] src_data_i = '0;
   logic          m_valid_o;
   logic          m_ready_i = 1'b0;
   logic [DW-1:0] m_data_o;
   logic          m_last_o;
   logic          busy_o;
   logic          done_o;

   burst_reader #(.DataWidth(DW), .MaxLen(ML)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
      .src_rvalid_i(src_rvalid_i), .src_rready_o(src_rready_o), .src_data_i(src_data_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rv_mode = 0;
   int rdy_mode = 0;
   int hs_cnt = 0;
   int pop_cnt = 0;
   int done_cnt = 0;
   int first_hs_cyc = -1;
   int first_pop_cyc = -1;
   int last_pop_cyc = -1;
   bit exp_done = 1'b0;
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] src_q [$];

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int eff_len(input int l);
      return (l > ML) ? ML : l;
   endfunction

   // Source: answers each read handshake one cycle later with the next word of the burst.
   initial begin
      bit pend;
      forever begin
         @(negedge clk_i);
         pend = src_rvalid_i && src_rready_o && !reset_i;
         if (pend) begin
            hs_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
         end
         @(posedge clk_i);
         #1;
         if (pend && src_q.size() == 0) begin
            chk("src_overread", 1, 0);
            src_data_i = DW'($urandom);
         end else if (pend) begin
            src_data_i = src_q.pop_front();
         end else begin
            src_data_i = DW'($urandom);
         end
         case (rv_mode)
            0:       src_rvalid_i = 1'b1;
            1:       src_rvalid_i = ~src_rvalid_i;
            default: src_rvalid_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (rdy_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = 1'($urandom_range(0, 1));
            default: m_ready_i = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every downstream handshake and tracks done timing.
   initial begin
      logic [DW:0] e;
      forever begin
         @(negedge clk_i);
         if (reset_i) begin
            exp_done = 1'b0;
         end else begin
            chk("done_o", done_o, exp_done);
            if (done_o) done_cnt++;
            exp_done = 1'b0;
            if (cmd_valid_i && cmd_ready_o && eff_len(int'(cmd_len_i)) == 0) exp_done = 1'b1;
            if (m_valid_o && m_ready_i) begin
               if (exp_q.size() == 0) begin
                  chk("extra_word", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("m_data_o", m_data_o, e[DW-1:0]);
                  chk("m_last_o", m_last_o, e[DW]);
                  if (e[DW]) exp_done = 1'b1;
               end
               pop_cnt++;
               if (first_pop_cyc < 0) first_pop_cyc = cyc;
               last_pop_cyc = cyc;
            end
         end
      end
   end

   task automatic send_cmd(input int len, input bit fixed, output bit done_at_accept);
      int  n;
      bit  ok;
      logic [DW-1:0] d;
      n = eff_len(len);
      ok = 1'b0;
      done_at_accept = 1'b0;
      cmd_len_i = LW'(len);
      cmd_valid_i = 1'b1;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin
            ok = 1'b1;
            done_at_accept = done_o;
            for (int k = 0; k < n; k++) begin
               d = fixed ? DW'(8'h11 * (k + 1)) : DW'($urandom);
               src_q.push_back(d);
               exp_q.push_back({k == n - 1, d});
            end
         end
      end
      if (!ok) chk("cmd_accept_timeout", 0, 1);
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
      cmd_len_i = LW'($urandom);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk_i);
         if (!busy_o && exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         chk("idle_timeout", 0, 1);
         exp_q.delete();
         src_q.delete();
      end
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      bit dacc;
      int p0;
      int h0;
      int d0;

      // reset state
      wait_cycles(3);
      @(negedge clk_i);
      chk("rst_cmd_ready", cmd_ready_o, 0);
      chk("rst_src_rready", src_rready_o, 0);
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_m_data", m_data_o, 0);
      chk("rst_m_last", m_last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      wait_cycles(2);

      // len=4 fixed data, full throughput
      rv_mode = 0; rdy_mode = 0;
      wait_cycles(2);
      first_hs_cyc = -1; first_pop_cyc = -1; p0 = pop_cnt;
      send_cmd(4, 1'b1, dacc);
      wait_idle();
      chk("first_word_latency", first_pop_cyc - first_hs_cyc, 2);
      chk("four_consecutive", last_pop_cyc - first_pop_cyc, 3);
      chk("len4_count", pop_cnt - p0, 4);

      // len=0
      h0 = hs_cnt; p0 = pop_cnt; d0 = done_cnt;
      send_cmd(0, 1'b0, dacc);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("len0_busy", busy_o, 0);
         chk("len0_src_rready", src_rready_o, 0);
         chk("len0_m_valid", m_valid_o, 0);
      end
      wait_cycles(1);
      chk("len0_reads", hs_cnt - h0, 0);
      chk("len0_done_pulses", done_cnt - d0, 1);

      // len=16 with a 10-cycle downstream stall
      send_cmd(16, 1'b0, dacc);
      wait_cycles(3);
      rdy_mode = 2;
      wait_cycles(11);
      #1;
      chk("stall_outstanding", hs_cnt - pop_cnt, 3);
      chk("stall_src_rready", src_rready_o, 0);
      rdy_mode = 0;
      wait_idle();

      // len=5 with toggling source valid
      rv_mode = 1;
      h0 = hs_cnt; p0 = pop_cnt;
      send_cmd(5, 1'b0, dacc);
      wait_idle();
      chk("toggle_reads", hs_cnt - h0, 5);
      chk("toggle_words", pop_cnt - p0, 5);
      rv_mode = 0;

      // reset mid-burst after two words
      p0 = pop_cnt;
      send_cmd(8, 1'b0, dacc);
      for (int i = 0; i < 200 && (pop_cnt - p0) < 2; i++) wait_cycles(1);
      reset_i = 1'b1;
      wait_cycles(1);
      chk("mid_rst_cmd_ready", cmd_ready_o, 0);
      chk("mid_rst_src_rready", src_rready_o, 0);
      chk("mid_rst_m_valid", m_valid_o, 0);
      chk("mid_rst_m_data", m_data_o, 0);
      chk("mid_rst_m_last", m_last_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_done", done_o, 0);
      exp_q.delete();
      src_q.delete();
      reset_i = 1'b0;
      p0 = pop_cnt;
      send_cmd(1, 1'b0, dacc);
      wait_idle();
      chk("post_rst_words", pop_cnt - p0, 1);

      // back-to-back 3 then 2, second accepted during done_o
      p0 = pop_cnt; d0 = done_cnt;
      send_cmd(3, 1'b0, dacc);
      send_cmd(2, 1'b0, dacc);
      chk("b2b_accept_in_done", dacc, 1);
      wait_idle();
      chk("b2b_words", pop_cnt - p0, 5);
      chk("b2b_done_pulses", done_cnt - d0, 2);

      // oversize length clamps to MaxLen
      p0 = pop_cnt;
      send_cmd(25, 1'b0, dacc);
      wait_idle();
      chk("clamp_words", pop_cnt - p0, ML);

      // randomized bursts with random source/sink pacing
      for (int t = 0; t < 30; t++) begin
         rv_mode = $urandom_range(0, 2);
         rdy_mode = $urandom_range(0, 1);
         send_cmd($urandom_range(0, 20), 1'b0, dacc);
      end
      rdy_mode = 0;
      wait_idle();
      chk("final_exp_empty", exp_q.size(), 0);
      chk("final_src_empty", src_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
